switch_egress_port: RTL
=======================

// Module: switch_egress_port
// PURPOSE
//  Egress/receive end of the 4-port switch fabric, one instance per output port.
//  Monitors the transmit buses (valid/source/target/data) of all NUM_PORTS switch ports.
//  Captures every beat whose one-hot target hits PORT_ID and merges simultaneous
//  arrivals round-robin into a FIFO. Drains to the port consumer over valid/ready.
// PARAMETERS
//  NUM_PORTS  4  number of switch ports observed; fixed at 4 to match 4-bit source/target
//  PORT_ID    0  index (0..NUM_PORTS-1) of this egress port; selects target bit checked
//  DEPTH      8  output FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               synchronous, active-high reset
//  in_valid    in   NUM_PORTS       bit i = valid_out of switch port i
//  in_source   in   4*NUM_PORTS     [4i+:4] = source_out of port i
//  in_target   in   4*NUM_PORTS     [4i+:4] = target_out of port i (one-hot)
//  in_data     in   8*NUM_PORTS     [8i+:8] = data_out of port i
//  out_valid   out  1               FIFO head valid
//  out_ready   in   1               consumer accepts head when out_valid&out_ready
//  out_source  out  4               source field of FIFO head
//  out_data    out  8               data of FIFO head
//  fifo_count  out  $clog2(DEPTH+1) entries held in FIFO
//  drop_cnt    out  8               saturating count of dropped beats
// BEHAVIOUR
//  Reset (rst=1 at edge): staging empty, FIFO empty, rr_ptr=0, drop_cnt=0.
//  After reset: out_valid=0, out_source=0, out_data=0, fifo_count=0. Reset mid-burst discards all.
//  Hit: hit[i] = in_valid[i] & in_target[4i+PORT_ID]. Other target bits are ignored.
//  Stage: one 12-bit register (source, data) plus full flag per input i.
//  Stage write: on hit[i], stage i loads at the edge.
//  Drop: hit[i] while stage i full and not granted this cycle -> beat lost, stage keeps old entry.
//  Each drop adds 1 to drop_cnt, saturating at 8'hFF. Simultaneous drops on k inputs add k.
//  Refill: a grant and a new hit on the same stage in one cycle -> old entry to FIFO, new entry staged.
//  Arbiter: scans stage full flags from rr_ptr upward, mod NUM_PORTS, and picks the first full one.
//  Grant condition: fifo_count<DEPTH, or a pop occurs this cycle (push+pop at full allowed).
//  Grant effects: entry pushed; stage i cleared unless refilled; rr_ptr <= i+1 (wraps 3->0).
//  No grant: rr_ptr holds.
//  Rate: at most one push per cycle.
//  FIFO: show-ahead; out_source/out_data are the head entry.
//  Pop: out_valid&out_ready; fifo_count updates next edge (+1 push, -1 pop, 0 both).
//  Empty: out_valid=0, and out_source/out_data hold their last value (0 after reset).
//  Latency: hit at edge N -> staged at N -> pushed at N+1 -> out_valid=1 after edge N+1 (2 cycles) when FIFO empty.
//  Ordering: per-source order is preserved. Cross-source order follows grant order.
//  FIFO pointers wrap mod DEPTH. Full and empty are distinguished by count.
// TESTING
//  1 PORT_ID=2; port0 sends src=1,tgt=4'b0100,data=8'hA5; out_ready=1
//    -> out_valid=1 two cycles later with src=1, data=A5; fifo_count returns 0.
//  2 Same cycle: ports 0,1,3 hit with data 11,22,33; rr_ptr=0
//    -> output order 11,22,33; rr_ptr=0 afterwards.
//    Repeat with rr_ptr=2 -> order 33,11,22.
//  3 Non-hit target 4'b1001 with PORT_ID=2 -> nothing captured; drop_cnt stays 0.
//  4 out_ready=0; port0 hits every cycle for 12 cycles (DEPTH=8)
//    -> fifo_count=8, stage0 full, drop_cnt=3.
//    Then out_ready=1 -> the 9 stored beats emerge in order, then out_valid=0.
//  5 FIFO full with out_ready=1 and stage full -> push+pop same cycle; fifo_count stays 8; no drop.
//  6 Assert rst for 1 cycle while FIFO holds 5 and drop_cnt=7
//    -> next cycle out_valid=0, fifo_count=0, drop_cnt=0; the next hit emerges after 2 cycles.

Source files
------------

// File: rtl/switch_egress_port.sv
// Egress end of the 4-port switch: captures beats targeted at PORT_ID and merges them round-robin into an output FIFO.
// Latency: a hit at edge N is staged at N and pushed at N+1, so out_valid rises 2 cycles after the hit when the FIFO is empty.
// Backpressure: out_ready stalls the FIFO; a full FIFO blocks grants; a hit on a full, ungranted stage is dropped and counted.
// Ports: clk/rst (sync, active-high); in_valid/in_source/in_target/in_data = transmit buses of all switch ports;
//        out_valid/out_ready/out_source/out_data = show-ahead FIFO head; fifo_count = entries held;
//        drop_cnt = saturating count of lost beats.
module switch_egress_port #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_ID   = 0,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [4*NUM_PORTS-1:0]     in_source,
  input  logic [4*NUM_PORTS-1:0]     in_target,
  input  logic [8*NUM_PORTS-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_source,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                 drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [3:0] source;
    logic [7:0] data;
  } beat_t;

  // Per-input staging registers
  beat_t                stg_dat [NUM_PORTS];
  logic [NUM_PORTS-1:0] stg_full;
  logic [PW-1:0]        rr_ptr;

  // Output FIFO
  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  beat_t         hold_dat;
  beat_t         head;

  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] drop;
  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        scan_idx;
  logic                 push;
  logic                 pop;
  logic [8:0]           drop_sum;
  logic [8:0]           drop_tot;
  logic [7:0]           drop_nxt;

  // Only our own target bit matters; the others are deliberately ignored.
  logic unused_tgt;
  assign unused_tgt = ^in_target;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign fifo_count = count;

  // With nothing queued, the outputs keep showing the last beat handed out.
  assign head       = out_valid ? mem[rd_ptr] : hold_dat;
  assign out_source = head.source;
  assign out_data   = head.data;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      hit[k] = in_valid[k] & in_target[4*k + PORT_ID];
    end
  end

  // Round-robin scan starting at rr_ptr; the first full stage wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!grant_vld && stg_full[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = grant_vld & ((count < CW'(DEPTH)) | pop);

  always_comb begin
    drop     = '0;
    drop_sum = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      drop[k]  = hit[k] & stg_full[k] & ~(push && (grant_idx == PW'(k)));
      drop_sum = drop_sum + 9'(drop[k]);
    end
    drop_tot = {1'b0, drop_cnt} + drop_sum;
    drop_nxt = drop_tot[8] ? 8'hFF : drop_tot[7:0];
  end

  // Stage occupancy: a hit that is not dropped always (re)loads the stage,
  // which covers both the empty case and refill-while-granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_full <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (hit[k] && !drop[k]) begin
          stg_full[k] <= 1'b1;
        end else if (push && (grant_idx == PW'(k))) begin
          stg_full[k] <= 1'b0;
        end
      end
      if (push) begin
        rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      end
      drop_cnt <= drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (hit[k] && !drop[k]) begin
        stg_dat[k] <= '{source: in_source[4*k +: 4], data: in_data[8*k +: 8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_dat <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        hold_dat <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= stg_dat[grant_idx];
    end
  end

endmodule
